// File: rtl/mips_dmem_responder.sv
// Memory-side responder for the processor data port: word RAM with a
// configurable wait-state latency, one-cycle ready pulse and a sticky completion mailbox.
module mips_dmem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] DONE_ADDR   = 32'd84
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        misaligned,
  output logic        done,
  output logic [31:0] done_value
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: the initiator holds memread/memwrite (and address/data) until it
  // sees ready; inputs are sampled only in IDLE, and ready is a single-cycle pulse
  // in RESP, after which a still-asserted request starts a new transaction.
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [31:0]   addr_q, data_q;
  logic          wr_q, rd_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          aligned;
  logic          commit;

  assign idx     = addr_q[AW+1:2];
  assign aligned = (addr_q[1:0] == 2'b00);
  assign commit  = (state == BUSY) && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (memread || memwrite) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A simultaneous read+write request is a store; the load side is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 4'd0;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      ready      <= 1'b0;
      misaligned <= 1'b0;
      readdata   <= 32'h0;
      done       <= 1'b0;
      done_value <= 32'h0;
    end else begin
      ready      <= 1'b0;
      misaligned <= 1'b0;
      readdata   <= 32'h0;
      case (state)
        IDLE: begin
          if (memread || memwrite) begin
            addr_q <= dataadr;
            data_q <= writedata;
            wr_q   <= memwrite;
            rd_q   <= memread & ~memwrite;
            cnt    <= 4'(WAIT_STATES);
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            ready      <= 1'b1;
            misaligned <= ~aligned;
            if (rd_q && aligned) readdata <= mem[idx];
            if (wr_q && aligned && (addr_q == DONE_ADDR) && !done) begin
              done       <= 1'b1;
              done_value <= data_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately not reset; a reset on the commit edge cancels the store.
  always_ff @(posedge clk) begin
    if (!reset && commit && wr_q && aligned) mem[idx] <= data_q;
  end

endmodule
